// File: rtl/serialtx_pkg.sv
// Shared definitions for the serialtx transmitter and its front-end arbiter.
package serialtx_pkg;

    typedef enum logic [1:0] {
        HOLDOFF,
        IDLE,
        ISSUE,
        WAIT
    } tx_state_e;

    localparam int BAUD_DIV_DEFAULT = 166;
    localparam int FRAME_BAUDS      = 11;

    // Worst-case frame length, including the unaligned RTS baud period.
    function automatic int frame_cycles(input int baud_div);
        return FRAME_BAUDS * (baud_div + 1);
    endfunction

endpackage

// File: rtl/serialtx_arbiter_if.sv
// Requester handshake and transmitter-side signals of the serialtx arbiter.
interface serialtx_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_txe;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic [15:0]       frames_sent;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_data, tx_txe, busy, grant_id, frames_sent
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_data, tx_txe, busy, grant_id, frames_sent
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after index `last`, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/serialtx_arbiter.sv
// Round-robin arbiter sequencing a shared serialtx transmitter from a local frame timer.
//
//   state   | meaning
//   HOLDOFF | after reset: let a possibly interrupted frame drain
//   IDLE    | look for a requester, accept its byte
//   ISSUE   | single-cycle txe pulse, count the frame
//   WAIT    | hold tx_data for one worst-case frame
module serialtx_arbiter
    import serialtx_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int BAUD_DIV     = BAUD_DIV_DEFAULT,
    parameter int FRAME_CYCLES = frame_cycles(BAUD_DIV),
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic clk,
    input  logic rst_n,
    serialtx_arbiter_if.slave bus
);

    localparam int             TW         = $clog2(FRAME_CYCLES);
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(FRAME_CYCLES - 1);

    tx_state_e      state;
    logic [TW-1:0]  timer;
    logic [IDW-1:0] last;
    logic [7:0]     tx_data_q;
    logic           tx_txe_q;
    logic [IDW-1:0] grant_q;
    logic [15:0]    frames_q;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic [7:0]     pick_data;
    logic           accept;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (bus.req_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_data = bus.req_data[{pick_idx, 3'b000} +: 8];
    assign accept    = (state == IDLE) && pick_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[pick_idx] = 1'b1;
    end

    assign bus.busy        = (state != IDLE);
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_txe      = tx_txe_q;
    assign bus.grant_id    = grant_q;
    assign bus.frames_sent = frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLDOFF;
            timer     <= TIMER_LOAD;
            last      <= IDW'(NREQ - 1);
            tx_data_q <= 8'hFF;
            tx_txe_q  <= 1'b0;
            grant_q   <= '0;
            frames_q  <= '0;
        end else begin
            tx_txe_q <= 1'b0;
            case (state)
                HOLDOFF, WAIT: begin
                    if (timer == '0) state <= IDLE;
                    else             timer <= timer - TW'(1);
                end
                IDLE: begin
                    if (pick_found) begin
                        tx_data_q <= pick_data;
                        grant_q   <= pick_idx;
                        last      <= pick_idx;
                        tx_txe_q  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    frames_q <= frames_q + 16'd1;
                    timer    <= TIMER_LOAD;
                    state    <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serialtx_arbiter.sv
// Scoreboard bench for serialtx_arbiter: rule-level model predicts grants, monitor checks DUT.
module tb_serialtx_arbiter;

    localparam int NREQ    = 4;
    localparam int FC      = 44;
    localparam int SPACING = FC + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serialtx_arbiter_if #(.NREQ(NREQ)) bus();

    serialtx_arbiter #(
        .NREQ     (NREQ),
        .BAUD_DIV (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [7:0]  data;
        logic [15:0] fs;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: requester queues plus arbitration rules in plain arithmetic
    bit          pend[NREQ];
    logic [7:0]  pdat[NREQ];
    int          last_m = NREQ - 1;
    int          elig   = 1 << 30;
    bit          acc_prev = 1'b0;
    int          acc_g, acc_c;
    logic [15:0] fs_m = '0;

    function automatic bit anyp();
        bit a = 1'b0;
        for (int i = 0; i < NREQ; i++) a |= pend[i];
        return a;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]       = pend[i];
            bus.req_data[8*i +: 8] = pdat[i];
        end
    endtask

    task automatic predict();
        bit hit = 1'b0;
        if (rst_n === 1'b1 && cyc >= elig) begin
            for (int k = 1; k <= NREQ; k++) begin
                int g = (last_m + k) % NREQ;
                if (!hit && pend[g]) begin
                    hit  = 1'b1;
                    fs_m = fs_m + 16'd1;
                    expq.push_back('{cyc, g, pdat[g], fs_m});
                    acc_prev = 1'b1;
                    acc_g    = g;
                    acc_c    = cyc;
                end
            end
        end
    endtask

    task automatic step();
        drive();
        predict();
        @(posedge clk);
        #1;
        if (acc_prev) begin
            pend[acc_g] = 1'b0;
            last_m      = acc_g;
            elig        = acc_c + SPACING;
            acc_prev    = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((cyc < elig || anyp()) && k < max) begin
            step();
            k++;
        end
        chk("wait_idle_timeout", 32'(k < max), 32'd1);
    endtask

    task automatic release_reset();
        rst_n  = 1'b1;
        elig   = cyc + FC;
        last_m = NREQ - 1;
        fs_m   = '0;
    endtask

    // Monitor: pops expectations when the DUT accepts, then follows the frame
    int   due = -1000;
    exp_t cur;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            expq.delete();
            due = -1000;
        end else begin
            chk("busy", 32'(bus.busy), 32'(cyc < elig));
            if (bus.req_ready != '0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_req_ready", 32'(bus.req_ready), 32'd0);
                end else begin
                    cur = expq.pop_front();
                    chk("accept_cycle", cyc, cur.cyc);
                    chk("req_ready", 32'(bus.req_ready), 32'd1 << cur.id);
                    due = cyc + 1;
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                chk("grant_missing", 32'(bus.req_ready), 32'd1 << expq[0].id);
                void'(expq.pop_front());
            end
            if (cyc == due) begin
                chk("txe_pulse", 32'(bus.tx_txe), 32'd1);
                chk("tx_data", 32'(bus.tx_data), 32'(cur.data));
                chk("grant_id", 32'(bus.grant_id), 32'(cur.id));
            end else begin
                chk("txe_quiet", 32'(bus.tx_txe), 32'd0);
            end
            if (cyc == due + 1) chk("frames_sent", 32'(bus.frames_sent), 32'(cur.fs));
            if (cyc == due + FC + 1) chk("tx_data_hold", 32'(bus.tx_data), 32'(cur.data));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
        end
        // Request 0 held through reset: served right after the holdoff
        pend[0] = 1'b1;
        pdat[0] = 8'hA5;
        run(3);
        chk("reset_tx_data", 32'(bus.tx_data), 32'hFF);
        chk("reset_frames", 32'(bus.frames_sent), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd1);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        release_reset();
        wait_idle(200);

        // All four at once, then a directed 3-before-1 case
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            pdat[i] = 8'($urandom);
        end
        wait_idle(400);
        pend[1] = 1'b1;
        pdat[1] = 8'($urandom);
        wait_idle(200);
        pend[1] = 1'b1;
        pdat[1] = 8'($urandom);
        pend[3] = 1'b1;
        pdat[3] = 8'($urandom);
        wait_idle(200);

        // Random arrivals, with occasional legal withdrawals while busy
        for (int s = 0; s < 1500; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(15) == 0) begin
                    pend[i] = 1'b1;
                    pdat[i] = 8'($urandom);
                end else if (pend[i] && cyc < elig && $urandom_range(63) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step();
        end
        wait_idle(800);

        // Reset in the middle of a 3C frame
        pend[2] = 1'b1;
        pdat[2] = 8'h3C;
        begin
            int k = 0;
            while (pend[2] && k < 200) begin
                step();
                k++;
            end
        end
        run(10);
        chk("pre_reset_tx_data", 32'(bus.tx_data), 32'h3C);
        pend[1] = 1'b1;
        pdat[1] = 8'($urandom);
        drive();
        rst_n    = 1'b0;
        acc_prev = 1'b0;
        #1;
        chk("midreset_tx_data", 32'(bus.tx_data), 32'hFF);
        chk("midreset_txe", 32'(bus.tx_txe), 32'd0);
        chk("midreset_frames", 32'(bus.frames_sent), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd1);
        chk("midreset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("midreset_grant_id", 32'(bus.grant_id), 32'd0);
        run(3);
        release_reset();
        wait_idle(200);

        // Frame counter wrap from a preloaded all-ones value
        force dut.frames_q = 16'hFFFF;
        run(1);
        release dut.frames_q;
        fs_m = 16'hFFFF;
        run(2);
        pend[0] = 1'b1;
        pdat[0] = 8'($urandom);
        wait_idle(200);
        run(5);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
